mdu_param: RTL and testbench

Parametrised multiply/divide unit for the E stage of the five-stage MIPS pipeline, driven by the decoder's `MDUStart`, `MDUOp` and `MDUClass` outputs. It executes mult/multu/div/divu over configurable multi-cycle latencies, owns the HI/LO registers, and serves mfhi/mflo/mthi/mtlo. It adds an exception-abort input from CP0 and a stall-request output, so D-stage hazard logic needs no knowledge of the latencies.

---
 rtl/mdu_param.sv | 224 ++++++++++++++++++++++
 tb/tb_mdu_param.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_param.sv
// -----------------------------------------------------------------------------
// mdu_param
// Multi-cycle multiply/divide unit for the E stage of a five-stage MIPS
// pipeline. It runs mult/multu/div/divu with parameterised latencies, holds
// the architectural HI/LO registers and serves mfhi/mflo/mthi/mtlo. It also
// raises a stall request, so hazard logic in D does not need to know the
// latencies.
//
// Parameters
//   WIDTH        operand and HI/LO width
//   MULT_CYCLES  busy cycles for mult/multu (>= 1)
//   DIV_CYCLES   busy cycles for div/divu   (>= 1)
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   start      in   E-stage instruction is an MDU start class
//   op         in   1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi,
//                   8 mtlo, anything else is a no-op
//   a          in   rs operand (dividend / multiplicand / mthi-mtlo data)
//   b          in   rt operand (divisor / multiplier)
//   abort      in   CP0 exception taken; the E-stage instruction must not commit
//   busy       out  a mult/div is in flight
//   stall_req  out  busy, or an arithmetic start being accepted this cycle
//   hi, lo     out  architectural HI / LO
//   rdata      out  hi for mfhi, lo for mflo, otherwise 0
// -----------------------------------------------------------------------------
module mdu_param #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MFHI  = 5'd5;
  localparam logic [4:0] OP_MFLO  = 5'd6;
  localparam logic [4:0] OP_MTHI  = 5'd7;
  localparam logic [4:0] OP_MTLO  = 5'd8;

  localparam logic [1:0] KIND_MULT  = 2'd0;
  localparam logic [1:0] KIND_MULTU = 2'd1;
  localparam logic [1:0] KIND_DIV   = 2'd2;
  localparam logic [1:0] KIND_DIVU  = 2'd3;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  logic             r_state;
  logic [1:0]       r_kind;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // ---------------------------------------------------------------------------
  // Decode of the incoming operation
  // ---------------------------------------------------------------------------
  logic             w_is_arith;
  logic             w_accept;
  logic [1:0]       w_kind_in;
  logic [CNT_W-1:0] w_cnt_load;

  assign w_is_arith = (op >= OP_MULT) && (op <= OP_DIVU);
  // Starts are only honoured from IDLE; a start during RUN is dropped.
  assign w_accept   = start && !abort && (r_state == S_IDLE);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    w_kind_in  = KIND_MULT;
    w_cnt_load = MULT_LOAD;
    case (op)
      OP_MULTU: w_kind_in = KIND_MULTU;
      OP_DIV: begin
        w_kind_in  = KIND_DIV;
        w_cnt_load = DIV_LOAD;
      end
      OP_DIVU: begin
        w_kind_in  = KIND_DIVU;
        w_cnt_load = DIV_LOAD;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath on the latched operands; sampled on the final RUN edge
  // ---------------------------------------------------------------------------
  logic               w_signed;
  logic               w_is_mul;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;

  assign w_signed = (r_kind == KIND_MULT) || (r_kind == KIND_DIV);
  assign w_is_mul = (r_kind == KIND_MULT) || (r_kind == KIND_MULTU);

  // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product are
  // then the exact signed or unsigned full product.
  assign w_a_ext = {{WIDTH{w_signed & r_a[WIDTH-1]}}, r_a};
  assign w_b_ext = {{WIDTH{w_signed & r_b[WIDTH-1]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_quot_mag;
  logic [WIDTH-1:0] w_rem_mag;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  // Divide on magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. min_int / -1 needs no special case: the
  // magnitude of min_int is 2^(WIDTH-1) as an unsigned value, the quotient
  // stays positive and wraps back to min_int, and the remainder is 0.
  assign w_a_neg    = w_signed & r_a[WIDTH-1];
  assign w_b_neg    = w_signed & r_b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -r_a : r_a;
  assign w_b_mag    = w_b_neg ? -r_b : r_b;
  assign w_div_zero = (r_b == '0);
  assign w_quot_mag = w_div_zero ? '0 : (w_a_mag / w_b_mag);
  assign w_rem_mag  = w_div_zero ? '0 : (w_a_mag % w_b_mag);
  assign w_quot     = (w_a_neg ^ w_b_neg) ? -w_quot_mag : w_quot_mag;
  assign w_rem      = w_a_neg ? -w_rem_mag : w_rem_mag;

  // ---------------------------------------------------------------------------
  // Control FSM, counter and HI/LO
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: reset clears the operand latches too; they are small registers,
      // not a memory, and a defined value keeps simulation X-free.
      r_state <= S_IDLE;
      r_kind  <= KIND_MULT;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_arith) begin
              r_a     <= a;
              r_b     <= b;
              r_kind  <= w_kind_in;
              r_cnt   <= w_cnt_load;
              r_state <= S_RUN;
            end else if (op == OP_MTHI) begin
              r_hi <= a;
            end else if (op == OP_MTLO) begin
              r_lo <= a;
            end
          end
        end
        S_RUN: begin
          // abort is ignored here: the instruction committed when it started.
          if (r_cnt == CNT_ONE) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            if (w_is_mul) begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end else if (!w_div_zero) begin
              r_hi <= w_rem;
              r_lo <= w_quot;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy      = (r_state == S_RUN);
  // Raised in the start cycle itself so a dependent mfhi/mflo in D stalls at once.
  assign stall_req = busy || (start && w_is_arith && !abort);
  assign hi        = r_hi;
  assign lo        = r_lo;

  always_comb begin
    rdata = '0;
    case (op)
      OP_MFHI: rdata = r_hi;
      OP_MFLO: rdata = r_lo;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mdu_param.sv
// -----------------------------------------------------------------------------
// tb_mdu_param
// Self-checking bench for mdu_param. Two instances run side by side: index 0
// with the default latencies (5/10) and index 1 with MULT_CYCLES=1,
// DIV_CYCLES=33. A plain-arithmetic reference model supplies HI/LO and the
// expected busy length for every operation.
// -----------------------------------------------------------------------------
module tb_mdu_param;

  logic        clk;
  logic        reset_v [2];
  logic        start_v [2];
  logic [4:0]  op_v    [2];
  logic [31:0] a_v     [2];
  logic [31:0] b_v     [2];
  logic        abort_v [2];
  logic        busy_v  [2];
  logic        stall_v [2];
  logic [31:0] hi_v    [2];
  logic [31:0] lo_v    [2];
  logic [31:0] rdata_v [2];

  int total;
  int bad;

  logic [31:0] m_hi [2];
  logic [31:0] m_lo [2];
  int          lat_mul [2];
  int          lat_div [2];

  mdu_param #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut0 (
    .clk(clk), .reset(reset_v[0]), .start(start_v[0]), .op(op_v[0]),
    .a(a_v[0]), .b(b_v[0]), .abort(abort_v[0]), .busy(busy_v[0]),
    .stall_req(stall_v[0]), .hi(hi_v[0]), .lo(lo_v[0]), .rdata(rdata_v[0])
  );

  mdu_param #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(33)) u_dut1 (
    .clk(clk), .reset(reset_v[1]), .start(start_v[1]), .op(op_v[1]),
    .a(a_v[1]), .b(b_v[1]), .abort(abort_v[1]), .busy(busy_v[1]),
    .stall_req(stall_v[1]), .hi(hi_v[1]), .lo(lo_v[1]), .rdata(rdata_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: new {hi,lo} for an arithmetic op, from plain integer math.
  function automatic logic [63:0] model(input logic [4:0] opc, input logic [31:0] av,
                                        input logic [31:0] bv, input logic [31:0] oh,
                                        input logic [31:0] ol);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              da, db;
    logic [63:0]     r;
    r = {oh, ol};
    case (opc)
      5'd1: begin
        sa = $signed(av);
        sb = $signed(bv);
        r  = 64'(sa * sb);
      end
      5'd2: begin
        ua = {32'd0, av};
        ub = {32'd0, bv};
        r  = ua * ub;
      end
      5'd3: begin
        da = $signed(av);
        db = $signed(bv);
        if (db == 0)                              r = {oh, ol};
        else if (da == 32'sh80000000 && db == -1) r = {32'd0, 32'h80000000};
        else                                      r = {32'(da % db), 32'(da / db)};
      end
      5'd4: begin
        if (bv == 0) r = {oh, ol};
        else         r = {av % bv, av / bv};
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic idle_inputs(input int idx);
    start_v[idx] = 1'b0;
    abort_v[idx] = 1'b0;
    op_v[idx]    = 5'd0;
    a_v[idx]     = '0;
    b_v[idx]     = '0;
  endtask

  task automatic do_reset(input int idx, input int cycles);
    idle_inputs(idx);
    reset_v[idx] = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset_v[idx] = 1'b0;
    m_hi[idx] = '0;
    m_lo[idx] = '0;
    check($sformatf("rst_busy%0d", idx), busy_v[idx], 0);
    check($sformatf("rst_hi%0d", idx), hi_v[idx], 0);
    check($sformatf("rst_lo%0d", idx), lo_v[idx], 0);
  endtask

  // Issue one mult/div and follow it to completion. Optionally pulse abort, or
  // inject an ignored div start, in the second busy cycle.
  task automatic run_op(input int idx, input logic [4:0] opc, input logic [31:0] av,
                        input logic [31:0] bv, input bit pulse_abort, input bit inject);
    logic [63:0] exp;
    int          n;
    int          lat;
    exp = model(opc, av, bv, m_hi[idx], m_lo[idx]);
    lat = (opc <= 5'd2) ? lat_mul[idx] : lat_div[idx];
    start_v[idx] = 1'b1;
    op_v[idx]    = opc;
    a_v[idx]     = av;
    b_v[idx]     = bv;
    #1;
    check($sformatf("stall_start%0d", idx), stall_v[idx], 1);
    check($sformatf("busy_pre%0d", idx), busy_v[idx], 0);
    @(posedge clk);
    #1;
    idle_inputs(idx);
    n = 0;
    while (busy_v[idx] && n < 100) begin
      n++;
      if (n == 1) check($sformatf("stall_run%0d", idx), stall_v[idx], 1);
      if (n == 2) begin
        if (pulse_abort) abort_v[idx] = 1'b1;
        if (inject) begin
          start_v[idx] = 1'b1;
          op_v[idx]    = 5'd3;
          a_v[idx]     = 32'd100;
          b_v[idx]     = 32'd7;
        end
      end
      @(posedge clk);
      #1;
      idle_inputs(idx);
    end
    check($sformatf("busy_len%0d_op%0d", idx, opc), n, lat);
    check($sformatf("hi%0d_op%0d", idx, opc), hi_v[idx], exp[63:32]);
    check($sformatf("lo%0d_op%0d", idx, opc), lo_v[idx], exp[31:0]);
    m_hi[idx] = exp[63:32];
    m_lo[idx] = exp[31:0];
  endtask

  task automatic move_to(input int idx, input logic [4:0] opc, input logic [31:0] val);
    start_v[idx] = 1'b1;
    op_v[idx]    = opc;
    a_v[idx]     = val;
    #1;
    check($sformatf("stall_mt%0d", idx), stall_v[idx], 0);
    @(posedge clk);
    #1;
    idle_inputs(idx);
    if (opc == 5'd7) m_hi[idx] = val;
    else             m_lo[idx] = val;
    check($sformatf("busy_mt%0d", idx), busy_v[idx], 0);
    check($sformatf("hi_mt%0d", idx), hi_v[idx], m_hi[idx]);
    check($sformatf("lo_mt%0d", idx), lo_v[idx], m_lo[idx]);
  endtask

  task automatic read_check(input int idx);
    op_v[idx] = 5'd5;
    #1;
    check($sformatf("mfhi%0d", idx), rdata_v[idx], m_hi[idx]);
    check($sformatf("mf_stall%0d", idx), stall_v[idx], 0);
    op_v[idx] = 5'd6;
    #1;
    check($sformatf("mflo%0d", idx), rdata_v[idx], m_lo[idx]);
    op_v[idx] = 5'd9;
    #1;
    check($sformatf("rdata_nop%0d", idx), rdata_v[idx], 0);
    op_v[idx] = 5'd0;
  endtask

  task automatic abort_start(input int idx);
    start_v[idx] = 1'b1;
    abort_v[idx] = 1'b1;
    op_v[idx]    = 5'd1;
    a_v[idx]     = 32'd1234;
    b_v[idx]     = 32'd5678;
    #1;
    check($sformatf("abort_stall%0d", idx), stall_v[idx], 0);
    @(posedge clk);
    #1;
    idle_inputs(idx);
    check($sformatf("abort_busy%0d", idx), busy_v[idx], 0);
    @(posedge clk);
    #1;
    check($sformatf("abort_busy2_%0d", idx), busy_v[idx], 0);
    check($sformatf("abort_hi%0d", idx), hi_v[idx], m_hi[idx]);
    check($sformatf("abort_lo%0d", idx), lo_v[idx], m_lo[idx]);
  endtask

  task automatic mid_run_reset(input int idx);
    start_v[idx] = 1'b1;
    op_v[idx]    = 5'd4;
    a_v[idx]     = 32'd1000;
    b_v[idx]     = 32'd3;
    @(posedge clk);
    #1;
    idle_inputs(idx);
    @(posedge clk);
    #1;
    reset_v[idx] = 1'b1;
    @(posedge clk);
    #1;
    reset_v[idx] = 1'b0;
    m_hi[idx] = '0;
    m_lo[idx] = '0;
    check($sformatf("midrst_busy%0d", idx), busy_v[idx], 0);
    check($sformatf("midrst_hi%0d", idx), hi_v[idx], 0);
    check($sformatf("midrst_lo%0d", idx), lo_v[idx], 0);
    repeat (lat_div[idx] + 2) @(posedge clk);
    #1;
    check($sformatf("midrst_hi_late%0d", idx), hi_v[idx], 0);
    check($sformatf("midrst_lo_late%0d", idx), lo_v[idx], 0);
  endtask

  task automatic random_run(input int idx, input int iters);
    logic [4:0]  ops [6];
    logic [4:0]  opc;
    logic [31:0] av, bv;
    ops = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd7, 5'd8};
    for (int i = 0; i < iters; i++) begin
      opc = ops[$urandom_range(0, 5)];
      av  = $urandom;
      bv  = $urandom;
      case ($urandom_range(0, 15))
        0, 1: bv = '0;
        2:    begin av = 32'h80000000; bv = 32'hFFFFFFFF; end
        3:    bv = $urandom_range(1, 9);
        4:    bv = 32'hFFFFFFFF - $urandom_range(0, 5);
        default: ;
      endcase
      if (opc == 5'd7 || opc == 5'd8) move_to(idx, opc, av);
      else run_op(idx, opc, av, bv, ($urandom_range(0, 3) == 0), 1'b0);
      read_check(idx);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    lat_mul = '{5, 1};
    lat_div = '{10, 33};
    for (int i = 0; i < 2; i++) begin
      reset_v[i] = 1'b1;
      idle_inputs(i);
      m_hi[i] = '0;
      m_lo[i] = '0;
    end
    @(posedge clk);
    #1;

    // ---- default latencies ----
    do_reset(0, 2);
    run_op(0, 5'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    check("mult_hi_const", hi_v[0], 32'hFFFFFFFF);
    check("mult_lo_const", lo_v[0], 32'hFFFFFFFA);
    run_op(0, 5'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    check("multu_hi_const", hi_v[0], 32'h00000002);
    check("multu_lo_const", lo_v[0], 32'hFFFFFFFA);
    run_op(0, 5'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    check("div_lo_const", lo_v[0], 32'hFFFFFFFD);
    check("div_hi_const", hi_v[0], 32'hFFFFFFFF);
    run_op(0, 5'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    check("divovf_lo_const", lo_v[0], 32'h80000000);
    check("divovf_hi_const", hi_v[0], 32'h00000000);
    move_to(0, 5'd7, 32'hCAFEF00D);
    run_op(0, 5'd4, 32'd7, 32'd0, 1'b0, 1'b0);
    check("divz_hi_const", hi_v[0], 32'hCAFEF00D);
    abort_start(0);
    run_op(0, 5'd2, 32'd123456, 32'd789, 1'b1, 1'b0);
    move_to(0, 5'd7, 32'h12345678);
    read_check(0);
    move_to(0, 5'd8, 32'h9ABCDEF0);
    read_check(0);
    run_op(0, 5'd4, 32'd1000, 32'd7, 1'b0, 1'b1);
    check("inject_lo_const", lo_v[0], 32'd142);
    check("inject_hi_const", hi_v[0], 32'd6);
    mid_run_reset(0);
    random_run(0, 30);

    // ---- MULT_CYCLES=1, DIV_CYCLES=33 ----
    do_reset(1, 2);
    run_op(1, 5'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    run_op(1, 5'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    run_op(1, 5'd4, 32'hFFFFFFFF, 32'd16, 1'b0, 1'b1);
    abort_start(1);
    mid_run_reset(1);
    random_run(1, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
